qspi_req_arb: RTL and testbench



---
 rtl/qspi_req_arb_pkg.sv | 51 +++++
 rtl/qspi_req_arb_fetch_buf.sv | 41 ++++
 rtl/qspi_req_arb.sv | 227 ++++++++++++++++++++++
 tb/tb_qspi_req_arb.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_req_arb_pkg.sv
// Shared types and helpers for the qspi_if request arbiter front end.
package qspi_req_arb_pkg;

    // Default flash address width forwarded to qspi_if
    localparam int ADR_W_DEF    = 24;
    // Default number of data grants tolerated while a fetch waits
    localparam int FAIR_MAX_DEF = 2;

    // Arbiter states: idle plus one busy state per kind of qspi_if access
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_IF = 2'd1,
        ST_RD_D  = 2'd2,
        ST_WR_D  = 2'd3
    } arb_state_e;

    // Client access size codes (3 behaves as a word)
    typedef enum logic [1:0] {
        SZ_BYTE     = 2'd0,
        SZ_HALF     = 2'd1,
        SZ_WORD     = 2'd2,
        SZ_WORD_ALT = 2'd3
    } size_e;

    // qspi_if length qualifiers: both low means a single byte
    typedef struct packed {
        logic w;
        logic hw;
    } qspi_len_t;

    // Map a client size code onto qspi_if's word/halfword qualifiers
    function automatic qspi_len_t size_to_len(input logic [1:0] size);
        qspi_len_t len;
        len.w  = 1'b0;
        len.hw = 1'b0;
        case (size_e'(size))
            SZ_BYTE: ;
            SZ_HALF: len.hw = 1'b1;
            default: len.w  = 1'b1;
        endcase
        return len;
    endfunction

    // Keep the low adr_w address bits and zero everything above them
    function automatic logic [31:0] qspi_adr(input logic [31:0] adr, input int adr_w);
        logic [31:0] mask;
        mask = (adr_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << adr_w) - 32'd1);
        return adr & mask;
    endfunction

endpackage

// File: rtl/qspi_req_arb_fetch_buf.sv
// Single-entry fetch buffer: one word tagged by its flash word address.
module qspi_req_arb_fetch_buf
    import qspi_req_arb_pkg::*;
#(
    parameter int TAG_W = ADR_W_DEF - 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [TAG_W-1:0] lookup_tag_i,
    output logic             hit_o,
    output logic [31:0]      word_o,
    input  logic             load_i,
    input  logic [TAG_W-1:0] load_tag_i,
    input  logic [31:0]      load_word_i,
    input  logic             inv_i,
    input  logic [TAG_W-1:0] inv_tag_i
);

    logic             valid_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      word_q;

    // Load on fetch completion; drop the entry when a write targets its word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            word_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            tag_q   <= load_tag_i;
            word_q  <= load_word_i;
        end else if (inv_i && valid_q && (inv_tag_i == tag_q)) begin
            valid_q <= 1'b0;
        end
    end

    assign hit_o  = valid_q && (lookup_tag_i == tag_q);
    assign word_o = word_q;

endmodule

// File: rtl/qspi_req_arb.sv
// Arbitrates an instruction-fetch port and a data port onto qspi_if's
// single-pulse read/write request interface, with a one-word fetch buffer.
module qspi_req_arb
    import qspi_req_arb_pkg::*;
#(
    parameter int ADR_W    = ADR_W_DEF,
    parameter int FAIR_MAX = FAIR_MAX_DEF   // must be at least 1
) (
    input  logic        clk,
    input  logic        rst_n,
    // instruction fetch client
    input  logic        if_req_i,
    input  logic [31:0] if_adr_i,
    output logic        if_ack_o,
    output logic [31:0] if_rdata_o,
    // data client
    input  logic        d_re_i,
    input  logic        d_we_i,
    input  logic [1:0]  d_size_i,
    input  logic [31:0] d_adr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_ack_o,
    output logic [31:0] d_rdata_o,
    // qspi_if side
    output logic        read_req_o,
    output logic        write_req_o,
    output logic        read_w_o,
    output logic        read_hw_o,
    output logic        write_w_o,
    output logic        write_hw_o,
    output logic [31:0] read_adr_o,
    output logic [31:0] write_adr_o,
    output logic [31:0] write_data_o,
    input  logic        read_valid_i,
    input  logic        write_finish_i,
    input  logic [31:0] read_data_i
);

    localparam int TAG_W = ADR_W - 2;
    localparam int CNT_W = $clog2(FAIR_MAX + 1);
    localparam logic [CNT_W-1:0] FAIR_CNT_MAX = CNT_W'(FAIR_MAX);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] fair_cnt_q, fair_cnt_d;

    logic        read_req_q, read_req_d;
    logic        write_req_q, write_req_d;
    logic        read_w_q, read_w_d;
    logic        read_hw_q, read_hw_d;
    logic        write_w_q, write_w_d;
    logic        write_hw_q, write_hw_d;
    logic [31:0] read_adr_q, read_adr_d;
    logic [31:0] write_adr_q, write_adr_d;
    logic [31:0] write_data_q, write_data_d;
    logic        if_ack_q, if_ack_d;
    logic        d_ack_q, d_ack_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic        buf_hit;
    logic [31:0] buf_word;
    logic        buf_load;
    logic        buf_inv;

    qspi_len_t   d_len;
    logic        fetch_forced;

    assign d_len        = size_to_len(d_size_i);
    // A waiting fetch overrides data once the data side has used its quota
    assign fetch_forced = if_req_i && (fair_cnt_q == FAIR_CNT_MAX);

    qspi_req_arb_fetch_buf #(
        .TAG_W (TAG_W)
    ) u_fetch_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_tag_i (if_adr_i[ADR_W-1:2]),
        .hit_o        (buf_hit),
        .word_o       (buf_word),
        .load_i       (buf_load),
        .load_tag_i   (read_adr_q[ADR_W-1:2]),
        .load_word_i  (read_data_i),
        .inv_i        (buf_inv),
        .inv_tag_i    (d_adr_i[ADR_W-1:2])
    );

    // Grant decision, completion handling and next values of all pulse/data registers
    always_comb begin
        state_d      = state_q;
        fair_cnt_d   = fair_cnt_q;
        read_req_d   = 1'b0;
        write_req_d  = 1'b0;
        read_w_d     = read_w_q;
        read_hw_d    = read_hw_q;
        write_w_d    = write_w_q;
        write_hw_d   = write_hw_q;
        read_adr_d   = read_adr_q;
        write_adr_d  = write_adr_q;
        write_data_d = write_data_q;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        buf_load     = 1'b0;
        buf_inv      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (if_req_i && buf_hit) begin
                    // served from the buffer without touching flash
                    if_ack_d   = 1'b1;
                    if_rdata_d = buf_word;
                    fair_cnt_d = '0;
                end else if (if_req_i && (fetch_forced || !(d_we_i || d_re_i))) begin
                    state_d    = ST_RD_IF;
                    read_req_d = 1'b1;
                    read_w_d   = 1'b1;
                    read_hw_d  = 1'b0;
                    read_adr_d = qspi_adr(if_adr_i, ADR_W);
                    fair_cnt_d = '0;
                end else if (d_we_i) begin
                    // write wins when both data strobes are high
                    state_d      = ST_WR_D;
                    write_req_d  = 1'b1;
                    write_w_d    = d_len.w;
                    write_hw_d   = d_len.hw;
                    write_adr_d  = qspi_adr(d_adr_i, ADR_W);
                    write_data_d = d_wdata_i;
                    buf_inv      = 1'b1;
                    if (if_req_i && (fair_cnt_q != FAIR_CNT_MAX)) begin
                        fair_cnt_d = fair_cnt_q + CNT_W'(1);
                    end
                end else if (d_re_i) begin
                    state_d    = ST_RD_D;
                    read_req_d = 1'b1;
                    read_w_d   = d_len.w;
                    read_hw_d  = d_len.hw;
                    read_adr_d = qspi_adr(d_adr_i, ADR_W);
                    if (if_req_i && (fair_cnt_q != FAIR_CNT_MAX)) begin
                        fair_cnt_d = fair_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RD_IF: begin
                if (read_valid_i) begin
                    state_d    = ST_IDLE;
                    if_ack_d   = 1'b1;
                    if_rdata_d = read_data_i;
                    buf_load   = 1'b1;
                end
            end
            ST_RD_D: begin
                if (read_valid_i) begin
                    state_d   = ST_IDLE;
                    d_ack_d   = 1'b1;
                    d_rdata_d = read_data_i;
                end
            end
            ST_WR_D: begin
                if (write_finish_i) begin
                    state_d = ST_IDLE;
                    d_ack_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and fairness counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fair_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fair_cnt_q <= fair_cnt_d;
        end
    end

    // Registered request/ack pulses, latched request fields and returned data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_req_q   <= 1'b0;
            write_req_q  <= 1'b0;
            read_w_q     <= 1'b0;
            read_hw_q    <= 1'b0;
            write_w_q    <= 1'b0;
            write_hw_q   <= 1'b0;
            read_adr_q   <= '0;
            write_adr_q  <= '0;
            write_data_q <= '0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            read_req_q   <= read_req_d;
            write_req_q  <= write_req_d;
            read_w_q     <= read_w_d;
            read_hw_q    <= read_hw_d;
            write_w_q    <= write_w_d;
            write_hw_q   <= write_hw_d;
            read_adr_q   <= read_adr_d;
            write_adr_q  <= write_adr_d;
            write_data_q <= write_data_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign read_req_o   = read_req_q;
    assign write_req_o  = write_req_q;
    assign read_w_o     = read_w_q;
    assign read_hw_o    = read_hw_q;
    assign write_w_o    = write_w_q;
    assign write_hw_o   = write_hw_q;
    assign read_adr_o   = read_adr_q;
    assign write_adr_o  = write_adr_q;
    assign write_data_o = write_data_q;
    assign if_ack_o     = if_ack_q;
    assign d_ack_o      = d_ack_q;
    assign if_rdata_o   = if_rdata_q;
    assign d_rdata_o    = d_rdata_q;

endmodule

// File: tb/tb_qspi_req_arb.sv
// Self-checking bench for qspi_req_arb: directed cases plus random traffic
// checked against a transaction-level model of the fetch buffer and grant rules.
module tb_qspi_req_arb;

    localparam int          FAIR_MAX = 2;
    localparam logic [31:0] AMASK    = 32'h00FF_FFFF;
    localparam logic [7:0]  G_D      = 8'h44;
    localparam logic [7:0]  G_I      = 8'h49;

    logic        clk;
    logic        rst_n;
    logic        if_req_i, if_ack_o;
    logic [31:0] if_adr_i, if_rdata_o;
    logic        d_re_i, d_we_i, d_ack_o;
    logic [1:0]  d_size_i;
    logic [31:0] d_adr_i, d_wdata_i, d_rdata_o;
    logic        read_req_o, write_req_o, read_w_o, read_hw_o, write_w_o, write_hw_o;
    logic [31:0] read_adr_o, write_adr_o, write_data_o;
    logic        read_valid_i, write_finish_i;
    logic [31:0] read_data_i;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // transaction-level model of the fetch buffer
    bit          mb_valid = 1'b0;
    logic [21:0] mb_tag   = '0;
    logic [31:0] mb_word  = '0;

    // qspi_if responder bookkeeping
    int          fixed_lat = 0;
    logic [31:0] rsp_data  = '0;
    int          rv_cyc    = 0;

    qspi_req_arb #(.ADR_W(24), .FAIR_MAX(FAIR_MAX)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_req_i       (if_req_i),
        .if_adr_i       (if_adr_i),
        .if_ack_o       (if_ack_o),
        .if_rdata_o     (if_rdata_o),
        .d_re_i         (d_re_i),
        .d_we_i         (d_we_i),
        .d_size_i       (d_size_i),
        .d_adr_i        (d_adr_i),
        .d_wdata_i      (d_wdata_i),
        .d_ack_o        (d_ack_o),
        .d_rdata_o      (d_rdata_o),
        .read_req_o     (read_req_o),
        .write_req_o    (write_req_o),
        .read_w_o       (read_w_o),
        .read_hw_o      (read_hw_o),
        .write_w_o      (write_w_o),
        .write_hw_o     (write_hw_o),
        .read_adr_o     (read_adr_o),
        .write_adr_o    (write_adr_o),
        .write_data_o   (write_data_o),
        .read_valid_i   (read_valid_i),
        .write_finish_i (write_finish_i),
        .read_data_i    (read_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // qspi_if behavioural responder: one access at a time, aborted by reset
    initial begin : responder
        int  lat;
        bit  is_rd;
        bit  abort;
        read_valid_i   = 1'b0;
        write_finish_i = 1'b0;
        read_data_i    = '0;
        forever begin
            @(negedge clk);
            if (rst_n && (read_req_o || write_req_o)) begin
                is_rd = read_req_o;
                lat   = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 6));
                abort = 1'b0;
                for (int i = 0; i < lat; i++) begin
                    @(negedge clk);
                    if (!rst_n) abort = 1'b1;
                end
                if (!abort && rst_n) begin
                    if (is_rd) begin
                        rsp_data     = $urandom;
                        read_data_i  = rsp_data;
                        read_valid_i = 1'b1;
                    end else begin
                        write_finish_i = 1'b1;
                    end
                    rv_cyc = cyc;
                    @(negedge clk);
                    read_valid_i   = 1'b0;
                    write_finish_i = 1'b0;
                    read_data_i    = $urandom;
                end
            end
        end
    end

    // One fetch transaction; expectation comes from the buffer model
    task automatic do_fetch(input logic [31:0] adr);
        bit exp_hit;
        bit done;
        int start;
        int nreq;
        int nwr;
        exp_hit  = mb_valid && (mb_tag == adr[23:2]);
        if_adr_i = adr;
        if_req_i = 1'b1;
        start    = cyc;
        nreq     = 0;
        nwr      = 0;
        done     = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (write_req_o) nwr++;
            if (read_req_o) begin
                nreq++;
                chk("fetch_grant_lat", 32'(cyc - start), 32'd1);
                chk("fetch_read_w", 32'(read_w_o), 32'd1);
                chk("fetch_read_hw", 32'(read_hw_o), 32'd0);
                chk("fetch_read_adr", read_adr_o, adr & AMASK);
            end
            if (if_ack_o) begin
                done     = 1'b1;
                if_req_i = 1'b0;
                if (exp_hit) begin
                    chk("hit_ack_lat", 32'(cyc - start), 32'd1);
                    chk("hit_rdata", if_rdata_o, mb_word);
                end else begin
                    chk("fetch_ack_lat", 32'(cyc), 32'(rv_cyc + 1));
                    chk("fetch_rdata", if_rdata_o, rsp_data);
                    mb_valid = 1'b1;
                    mb_tag   = adr[23:2];
                    mb_word  = rsp_data;
                end
            end
        end
        if_req_i = 1'b0;
        chk("fetch_done", 32'(done), 32'd1);
        chk("fetch_nreq", 32'(nreq), exp_hit ? 32'd0 : 32'd1);
        chk("fetch_nwr", 32'(nwr), 32'd0);
        $display("fetch adr=%08h hit=%0d rdata=%08h", adr, exp_hit, if_rdata_o);
        @(negedge clk);
    endtask

    // One data transaction; write wins when both strobes are set
    task automatic do_data(input bit re, input bit we, input logic [1:0] size,
                           input logic [31:0] adr, input logic [31:0] wdata);
        bit done;
        int nrd;
        int nwr;
        logic [31:0] exp_w;
        logic [31:0] exp_hw;
        exp_w     = (size >= 2'd2) ? 32'd1 : 32'd0;
        exp_hw    = (size == 2'd1) ? 32'd1 : 32'd0;
        d_re_i    = re;
        d_we_i    = we;
        d_size_i  = size;
        d_adr_i   = adr;
        d_wdata_i = wdata;
        nrd       = 0;
        nwr       = 0;
        done      = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (if_ack_o) chk("data_spurious_if_ack", 32'(if_ack_o), 32'd0);
            if (write_req_o) begin
                nwr++;
                chk("wr_w", 32'(write_w_o), exp_w);
                chk("wr_hw", 32'(write_hw_o), exp_hw);
                chk("wr_adr", write_adr_o, adr & AMASK);
                chk("wr_data", write_data_o, wdata);
                if (mb_valid && (mb_tag == adr[23:2])) mb_valid = 1'b0;
            end
            if (read_req_o) begin
                nrd++;
                chk("rd_w", 32'(read_w_o), exp_w);
                chk("rd_hw", 32'(read_hw_o), exp_hw);
                chk("rd_adr", read_adr_o, adr & AMASK);
            end
            if (d_ack_o) begin
                done   = 1'b1;
                d_re_i = 1'b0;
                d_we_i = 1'b0;
                chk("d_ack_lat", 32'(cyc), 32'(rv_cyc + 1));
                if (!we) chk("d_rdata", d_rdata_o, rsp_data);
            end
        end
        d_re_i = 1'b0;
        d_we_i = 1'b0;
        chk("data_done", 32'(done), 32'd1);
        chk("data_nwr", 32'(nwr), we ? 32'd1 : 32'd0);
        chk("data_nrd", 32'(nrd), we ? 32'd0 : 32'd1);
        $display("data %s adr=%08h size=%0d wdata=%08h rdata=%08h",
                 we ? "write" : "read ", adr, size, wdata, d_rdata_o);
        @(negedge clk);
    endtask

    initial begin : main
        logic [7:0]  got[$];
        logic [31:0] pool[8];
        bit          done;
        int          nev;
        pool = '{32'h0000_0100, 32'h0000_0104, 32'hFF00_0100, 32'h0000_0200,
                 32'h0000_0102, 32'h0000_0203, 32'h0000_5000, 32'h1200_0104};

        rst_n     = 1'b0;
        if_req_i  = 1'b0;
        if_adr_i  = '0;
        d_re_i    = 1'b0;
        d_we_i    = 1'b0;
        d_size_i  = '0;
        d_adr_i   = '0;
        d_wdata_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_if_ack", 32'(if_ack_o), 32'd0);
        chk("rst_d_ack", 32'(d_ack_o), 32'd0);
        chk("rst_read_req", 32'(read_req_o), 32'd0);
        chk("rst_write_req", 32'(write_req_o), 32'd0);
        chk("rst_if_rdata", if_rdata_o, 32'd0);
        chk("rst_d_rdata", d_rdata_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // long flash latency miss, then a buffer hit
        fixed_lat = 40;
        do_fetch(32'h0000_0100);
        fixed_lat = 0;
        chk("t1_rdata_nonzero_path", 32'(mb_valid), 32'd1);
        do_fetch(32'h0000_0100);
        // byte write into the buffered word invalidates it
        do_data(1'b0, 1'b1, 2'd0, 32'h0000_0102, 32'h0000_00A5);
        do_fetch(32'h0000_0100);
        // upper address bits beyond the flash width are dropped
        do_fetch(32'hFF00_0010);

        // fairness: fetch and data both pending, data re-requested back to back
        if_adr_i = 32'h0000_0300;
        if_req_i = 1'b1;
        d_adr_i  = 32'h0000_4000;
        d_size_i = 2'd2;
        d_we_i   = 1'b0;
        d_re_i   = 1'b1;
        done     = 1'b0;
        for (int k = 0; k < 1000 && !done; k++) begin
            @(negedge clk);
            if (read_req_o) got.push_back((read_adr_o == 32'h0000_0300) ? G_I : G_D);
            if (if_ack_o) begin
                done     = 1'b1;
                if_req_i = 1'b0;
                d_re_i   = 1'b0;
                chk("fair_if_rdata", if_rdata_o, rsp_data);
                mb_valid = 1'b1;
                mb_tag   = 22'(32'h0000_0300 >> 2);
                mb_word  = rsp_data;
            end
        end
        if_req_i = 1'b0;
        d_re_i   = 1'b0;
        chk("fair_done", 32'(done), 32'd1);
        chk("fair_ngrants", 32'(got.size()), 32'(FAIR_MAX + 1));
        for (int i = 0; i < got.size() && i <= FAIR_MAX; i++) begin
            chk("fair_order", 32'(got[i]), (i < FAIR_MAX) ? 32'(G_D) : 32'(G_I));
        end
        $display("fairness grants observed=%0d", got.size());
        @(negedge clk);

        // both data strobes high, halfword: only the write goes out
        do_data(1'b1, 1'b1, 2'd1, 32'h0000_2000, 32'h0000_BEEF);

        // random mixed traffic
        for (int n = 0; n < 60; n++) begin
            int op;
            logic [31:0] a;
            op = int'($urandom_range(0, 3));
            a  = pool[$urandom_range(0, 7)];
            case (op)
                0, 1: do_fetch(a & 32'hFFFF_FFFC);
                2:    do_data(1'b1, 1'b0, 2'($urandom_range(0, 3)), a, $urandom);
                default: do_data($urandom_range(0, 1) == 1, 1'b1, 2'($urandom_range(0, 3)), a, $urandom);
            endcase
        end

        // reset while a data read waits on flash
        d_adr_i  = 32'h0000_3000;
        d_size_i = 2'd2;
        d_re_i   = 1'b1;
        done     = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (read_req_o) done = 1'b1;
        end
        chk("rst5_req_seen", 32'(done), 32'd1);
        fixed_lat = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst5_if_ack", 32'(if_ack_o), 32'd0);
        chk("rst5_d_ack", 32'(d_ack_o), 32'd0);
        chk("rst5_read_req", 32'(read_req_o), 32'd0);
        chk("rst5_write_req", 32'(write_req_o), 32'd0);
        chk("rst5_if_rdata", if_rdata_o, 32'd0);
        chk("rst5_d_rdata", d_rdata_o, 32'd0);
        chk("rst5_read_adr", read_adr_o, 32'd0);
        d_re_i   = 1'b0;
        mb_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        nev   = 0;
        repeat (12) begin
            @(negedge clk);
            if (d_ack_o || if_ack_o || read_req_o || write_req_o) nev++;
        end
        chk("rst5_no_activity", 32'(nev), 32'd0);
        do_fetch(32'h0000_0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
